educ8_timing_gen: RTL and testbench

//  Major-state / time-state generator for the EDUC-8 control section. Sequences FETCH, DEFER
//  and EXECUTE major cycles, each of four time states T0..T3, and drives the address and

---
 rtl/educ8_timing_gen_pkg.sv | 58 +++++
 rtl/educ8_timing_gen_tick_div.sv | 52 +++++
 rtl/educ8_timing_gen.sv | 112 +++++++++++
 tb/tb_educ8_timing_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/educ8_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// educ8_timing_gen_pkg
//  Shared definitions for the EDUC-8 major-state / time-state generator:
//   - major-state encodings (FETCH, DEFER, EXEC; encoding 3 is never entered)
//   - opcode constants the sequencer needs to pick the next major cycle
//   - time-state width and the last time state of a major cycle
//   - next_major_f(): the major-cycle transition table, kept here so any other
//     block that needs to predict the next cycle uses the same decision.
// -----------------------------------------------------------------------------
package educ8_timing_gen_pkg;

  // Major-state encodings, driven straight out on the 'major' port.
  typedef enum logic [1:0] {
    MS_FETCH = 2'd0,
    MS_DEFER = 2'd1,
    MS_EXEC  = 2'd2,
    MS_RSVD  = 2'd3
  } major_t;

  // Opcodes that change the shape of an instruction.
  localparam logic [2:0] OP_JMP = 3'd5;  // JMP: address is the whole job
  localparam logic [2:0] OP_IOT = 3'd6;  // IOT: completes in FETCH
  localparam logic [2:0] OP_OPR = 3'd7;  // OPR: completes in FETCH

  // Time states T0..T3.
  localparam int          TS_W    = 2;
  localparam logic [TS_W-1:0] TS_LAST = 2'd3;

  // Major cycle that follows 'cur' given the instruction register contents.
  //  FETCH: IOT/OPR finish here; otherwise an indirect reference needs DEFER;
  //         a direct JMP is finished once the address is known; everything
  //         else goes to EXEC.
  //  DEFER: JMP is finished once the effective address is fetched.
  //  EXEC : always back to FETCH.
  //  The reserved encoding recovers to FETCH rather than wedging.
  function automatic major_t next_major_f(input major_t     cur,
                                          input logic [2:0] op,
                                          input logic       ind);
    major_t nxt;
    nxt = MS_FETCH;
    case (cur)
      MS_FETCH: begin
        if (op == OP_IOT || op == OP_OPR) nxt = MS_FETCH;
        else if (ind)                     nxt = MS_DEFER;
        else if (op == OP_JMP)            nxt = MS_FETCH;
        else                              nxt = MS_EXEC;
      end
      MS_DEFER: begin
        if (op == OP_JMP) nxt = MS_FETCH;
        else              nxt = MS_EXEC;
      end
      MS_EXEC:  nxt = MS_FETCH;
      default:  nxt = MS_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/educ8_timing_gen_tick_div.sv
// -----------------------------------------------------------------------------
// em_tick_div
//  Time-state prescaler. Counts 0..CLK_DIV-1 while enabled and flags the clk
//  on which the count reaches CLK_DIV-1; the time state advances on that edge.
//  With CLK_DIV=1 the counter never leaves 0 and tick simply follows en.
//
//  Ports
//   clk   in  1  system clock
//   nclr  in  1  asynchronous active-low reset
//   en    in  1  count enable (sequencer running)
//   sclr  in  1  synchronous clear (held while the sequencer is stopped so the
//                first time state after RUN is a full CLK_DIV clocks long)
//   tick  out 1  combinational strobe from the registered count
// -----------------------------------------------------------------------------
module em_tick_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic nclr,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  // Values below 1 make no sense; treat them as "advance every clk".
  localparam int DIV_EFF = (CLK_DIV < 1) ? 1 : CLK_DIV;
  localparam int CNT_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_EFF - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign tick = en && (count_reg == CNT_LAST);

  always_comb begin
    count_next = count_reg;
    if (sclr) begin
      count_next = '0;
    end else if (en) begin
      count_next = tick ? '0 : count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/educ8_timing_gen.sv
// -----------------------------------------------------------------------------
// educ8_timing_gen
//  Major-state / time-state generator for the EDUC-8 control section.
//  Steps through FETCH, DEFER and EXEC major cycles of four time states each
//  and feeds the em_74138 time-state decoder (tstate -> a[1:0], dec_en ->
//  enables). RUN/HALT/STEP come from the front panel; opcode/indirect come
//  from the instruction register and are only looked at on cycle_end.
//
//  Parameters
//   CLK_DIV     clk cycles per time state (>=1)
//
//  Ports
//   clk         in   1  system clock
//   nclr        in   1  asynchronous active-low reset
//   run_req     in   1  RUN request (level)
//   halt_req    in   1  HALT request (level, only honoured at cycle_end)
//   sstep       in   1  stop at every instruction boundary
//   opcode      in   3  IR[0:2]
//   indirect    in   1  IR indirect bit
//   tstate      out  2  current time state T0..T3
//   major       out  2  current major state (0 FETCH, 1 DEFER, 2 EXEC)
//   dec_en      out  1  decoder enable, identical to running
//   running     out  1  sequencer active
//   tick        out  1  time state advances on this clk edge
//   cycle_end   out  1  tick during T3
//   instr_done  out  1  cycle_end whose next major cycle is FETCH
// -----------------------------------------------------------------------------
module educ8_timing_gen
  import educ8_timing_gen_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       nclr,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       sstep,
  input  logic [2:0] opcode,
  input  logic       indirect,
  output logic [1:0] tstate,
  output logic [1:0] major,
  output logic       dec_en,
  output logic       running,
  output logic       tick,
  output logic       cycle_end,
  output logic       instr_done
);

  logic            running_reg;
  logic [TS_W-1:0] tstate_reg;
  major_t          major_reg;
  major_t          major_next;
  logic            stop_next;
  logic            tick_int;

  // Prescaler: counts only while running and is held clear while stopped,
  // so RUN sampled at edge N gives the first tick at edge N+CLK_DIV.
  em_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .nclr (nclr),
    .en   (running_reg),
    .sclr (!running_reg),
    .tick (tick_int)
  );

  // Next major cycle and the stop decision are computed every clk but only
  // take effect on cycle_end. halt_req is a level sampled there, so a HALT
  // raised mid-cycle still lets the cycle finish.
  always_comb begin
    major_next = next_major_f(major_reg, opcode, indirect);
    stop_next  = halt_req || (sstep && (major_next == MS_FETCH));
  end

  // Sequencer. Stopped: wait for RUN without HALT. Running: advance the time
  // state on each tick; the 3->0 wrap closes the major cycle. When a stop is
  // taken the wrap has already returned tstate to T0 and major holds the
  // cycle that would have run next, so a later RUN resumes right there.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      running_reg <= 1'b0;
      tstate_reg  <= '0;
      major_reg   <= MS_FETCH;
    end else if (!running_reg) begin
      if (run_req && !halt_req) begin
        running_reg <= 1'b1;
        tstate_reg  <= '0;
      end
    end else if (tick_int) begin
      tstate_reg <= tstate_reg + TS_W'(1);
      if (tstate_reg == TS_LAST) begin
        major_reg <= major_next;
        if (stop_next) begin
          running_reg <= 1'b0;
        end
      end
    end
  end

  // Strobes are derived from registered state; tick_int is already gated by
  // running, so all three are low while stopped.
  assign tick       = tick_int;
  assign cycle_end  = tick_int && (tstate_reg == TS_LAST);
  assign instr_done = cycle_end && (major_next == MS_FETCH);

  assign tstate  = tstate_reg;
  assign major   = major_reg;
  assign running = running_reg;
  assign dec_en  = running_reg;

endmodule

// File: tb/tb_educ8_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_educ8_timing_gen
//  Directed bench for educ8_timing_gen. Two instances share every input:
//  dut (CLK_DIV=1) carries most of the sequence, dut3 (CLK_DIV=3) is checked
//  after both have been reset together.
// -----------------------------------------------------------------------------
module tb_educ8_timing_gen;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DEFER = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  logic       clk = 1'b0;
  logic       nclr;
  logic       run_req;
  logic       halt_req;
  logic       sstep;
  logic [2:0] opcode;
  logic       indirect;

  logic [1:0] tstate, major;
  logic       dec_en, running, tick, cycle_end, instr_done;
  logic [1:0] tstate3, major3;
  logic       dec_en3, running3, tick3, cycle_end3, instr_done3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  educ8_timing_gen #(.CLK_DIV(1)) dut (
    .clk        (clk),
    .nclr       (nclr),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .sstep      (sstep),
    .opcode     (opcode),
    .indirect   (indirect),
    .tstate     (tstate),
    .major      (major),
    .dec_en     (dec_en),
    .running    (running),
    .tick       (tick),
    .cycle_end  (cycle_end),
    .instr_done (instr_done)
  );

  educ8_timing_gen #(.CLK_DIV(3)) dut3 (
    .clk        (clk),
    .nclr       (nclr),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .sstep      (sstep),
    .opcode     (opcode),
    .indirect   (indirect),
    .tstate     (tstate3),
    .major      (major3),
    .dec_en     (dec_en3),
    .running    (running3),
    .tick       (tick3),
    .cycle_end  (cycle_end3),
    .instr_done (instr_done3)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clk; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stopped(input string tag, input logic [1:0] exp_major);
    chk({tag, ".running"}, {3'b0, running}, 4'd0);
    chk({tag, ".dec_en"},  {3'b0, dec_en},  4'd0);
    chk({tag, ".tick"},    {3'b0, tick},    4'd0);
    chk({tag, ".tstate"},  {2'b0, tstate},  4'd0);
    chk({tag, ".major"},   {2'b0, major},   {2'b0, exp_major});
  endtask

  // Starting at T0 of a major cycle on dut, walk T0..T3 and step into the
  // following cycle.
  task automatic check_cycle(input string tag, input logic [1:0] exp_major,
                             input logic exp_done);
    for (int t = 0; t < 4; t++) begin
      chk({tag, ".tstate"},     {2'b0, tstate},      4'(t));
      chk({tag, ".major"},      {2'b0, major},       {2'b0, exp_major});
      chk({tag, ".dec_en"},     {3'b0, dec_en},      4'd1);
      chk({tag, ".tick"},       {3'b0, tick},        4'd1);
      chk({tag, ".cycle_end"},  {3'b0, cycle_end},   {3'b0, (t == 3)});
      chk({tag, ".instr_done"}, {3'b0, instr_done},  {3'b0, (t == 3) && exp_done});
      step();
    end
    $display("cycle %s major=%0d done=%0d checks=%0d", tag, exp_major, exp_done, checks);
  endtask

  initial begin
    nclr = 1'b0; run_req = 1'b0; halt_req = 1'b0; sstep = 1'b0;
    opcode = 3'd1; indirect = 1'b0;

    // Reset state
    step(); step();
    chk_stopped("reset", FETCH);
    chk("reset.cycle_end",  {3'b0, cycle_end},  4'd0);
    chk("reset.instr_done", {3'b0, instr_done}, 4'd0);
    chk("reset.running3",   {3'b0, running3},   4'd0);
    nclr = 1'b1;
    step();
    chk_stopped("idle", FETCH);

    // 1: one-clk RUN pulse, opcode 1 direct -> FETCH then EXEC
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    chk("run.running", {3'b0, running}, 4'd1);
    check_cycle("t1.fetch", FETCH, 1'b0);
    check_cycle("t1.exec",  EXEC,  1'b1);

    // 2: instruction shapes
    opcode = 3'd3; indirect = 1'b1;
    check_cycle("t2a.fetch", FETCH, 1'b0);
    check_cycle("t2a.defer", DEFER, 1'b0);
    check_cycle("t2a.exec",  EXEC,  1'b1);
    opcode = 3'd5; indirect = 1'b1;
    check_cycle("t2b.fetch", FETCH, 1'b0);
    check_cycle("t2b.defer", DEFER, 1'b1);
    opcode = 3'd7; indirect = 1'b0;
    check_cycle("t2c.fetch0", FETCH, 1'b1);
    check_cycle("t2c.fetch1", FETCH, 1'b1);
    opcode = 3'd5; indirect = 1'b0;
    check_cycle("t2d.jmp", FETCH, 1'b1);
    opcode = 3'd6; indirect = 1'b1;
    check_cycle("t2e.iot", FETCH, 1'b1);

    // 3: HALT raised at FETCH T1 lets the cycle finish
    opcode = 3'd1; indirect = 1'b0;
    step();
    chk("t3.t1", {2'b0, tstate}, 4'd1);
    halt_req = 1'b1;
    step();
    chk("t3.t2.running", {3'b0, running}, 4'd1);
    step();
    chk("t3.t3.cycle_end",  {3'b0, cycle_end},  4'd1);
    chk("t3.t3.instr_done", {3'b0, instr_done}, 4'd0);
    step();
    chk_stopped("t3.halted", EXEC);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3.idle.tick", {3'b0, tick}, 4'd0);
    end
    chk("t3.idle.tstate", {2'b0, tstate}, 4'd0);
    run_req = 1'b1;
    step(); step();
    chk("t3.runhalt.running", {3'b0, running}, 4'd0);
    halt_req = 1'b0;
    step();
    run_req = 1'b0;
    chk("t3.resume.running", {3'b0, running}, 4'd1);
    check_cycle("t3.resume.exec", EXEC, 1'b1);
    // Halt at the end of a one-cycle OPR so the stop lands on FETCH
    opcode = 3'd7; halt_req = 1'b1;
    check_cycle("t3.opr", FETCH, 1'b1);
    chk_stopped("t3.stop2", FETCH);
    halt_req = 1'b0;

    // 4: single-instruction mode with RUN held
    sstep = 1'b1; run_req = 1'b1; opcode = 3'd2; indirect = 1'b0;
    step();
    check_cycle("t4.fetch", FETCH, 1'b0);
    check_cycle("t4.exec",  EXEC,  1'b1);
    chk_stopped("t4.gap", FETCH);
    step();
    chk("t4.restart.running", {3'b0, running}, 4'd1);
    run_req = 1'b0;
    check_cycle("t4.fetch2", FETCH, 1'b0);
    check_cycle("t4.exec2",  EXEC,  1'b1);
    chk_stopped("t4.stop", FETCH);
    step();
    chk("t4.hold.running", {3'b0, running}, 4'd0);
    sstep = 1'b0;

    // 6: asynchronous reset at DEFER T2
    opcode = 3'd3; indirect = 1'b1; run_req = 1'b1;
    step();
    run_req = 1'b0;
    check_cycle("t6.fetch", FETCH, 1'b0);
    step(); step();
    chk("t6.t2.tstate", {2'b0, tstate}, 4'd2);
    chk("t6.t2.major",  {2'b0, major},  {2'b0, DEFER});
    #2 nclr = 1'b0;
    #1;
    chk_stopped("t6.async", FETCH);
    chk("t6.async.cycle_end",  {3'b0, cycle_end},  4'd0);
    chk("t6.async.instr_done", {3'b0, instr_done}, 4'd0);
    step();
    nclr = 1'b1;
    step();
    chk_stopped("t6.after", FETCH);

    // 5: restart both instances; dut3 ticks every third clk
    opcode = 3'd1; indirect = 1'b0; run_req = 1'b1;
    step();
    run_req = 1'b0;
    chk("t6.restart.running", {3'b0, running}, 4'd1);
    chk("t6.restart.tstate",  {2'b0, tstate},  4'd0);
    chk("t5.k0.running3", {3'b0, running3}, 4'd1);
    chk("t5.k0.tick3",    {3'b0, tick3},    4'd0);
    chk("t5.k0.tstate3",  {2'b0, tstate3},  4'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t5.tick3",      {3'b0, tick3},      {3'b0, (k % 3) == 2});
      chk("t5.tstate3",    {2'b0, tstate3},    4'((k / 3) % 4));
      chk("t5.cycle_end3", {3'b0, cycle_end3}, {3'b0, k == 11});
      chk("t5.major3",     {2'b0, major3},     (k == 12) ? {2'b0, EXEC} : {2'b0, FETCH});
    end
    $display("cycle t5.div3 checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
